mem_wb_pipe: RTL and testbench

//  Parametrised MEM->WB pipeline register for the 5-stage RV32I core with hazard unit.
//  - Carries rd, write-back control, ALU result and raw data-memory word through STAGES register slots.
//  - Adds per-slot valid, stall (hold) and flush (bubble).
//  - Performs load byte/half selection with sign/zero extension and the final write-back mux.
//  - Provides forwarding-hit flags for the EX-stage source registers.

---
 rtl/mem_wb_pipe.sv | 119 +++++++++++
 tb/tb_mem_wb_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register chain with per-slot valid, stall/flush control,
// load byte/half extraction, write-back mux and EX-stage forwarding-hit flags.
module mem_wb_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RA_W   = 5,
    parameter int unsigned STAGES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            valid_mem,
    input  logic [RA_W-1:0] rd_mem,
    input  logic            im_to_rf_mem,
    input  logic            load_mem,
    input  logic [2:0]      funct3_mem,
    input  logic [XLEN-1:0] alu_data_mem,
    input  logic [XLEN-1:0] dm_data_mem,
    input  logic [RA_W-1:0] rs1_ex,
    input  logic [RA_W-1:0] rs2_ex,
    output logic            valid_wb,
    output logic [RA_W-1:0] rd_wb,
    output logic            reg_write_wb,
    output logic [XLEN-1:0] wb_data,
    output logic            misalign_wb,
    output logic            fwd_rs1,
    output logic            fwd_rs2
);

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            im_to_rf;
        logic            load;
        logic [2:0]      funct3;
        logic [1:0]      off;
        logic [XLEN-1:0] alu_data;
        logic [XLEN-1:0] dm_data;
    } slot_t;

    if (STAGES < 1) begin : g_bad_stages
        $error("mem_wb_pipe: STAGES must be at least 1");
    end

    slot_t slot_in;
    slot_t slot_q [STAGES];
    slot_t last;

    always_comb begin
        slot_in          = '0;
        slot_in.valid    = valid_mem;
        slot_in.rd       = rd_mem;
        slot_in.im_to_rf = im_to_rf_mem;
        slot_in.load     = load_mem;
        slot_in.funct3   = funct3_mem;
        slot_in.off      = alu_data_mem[1:0];
        slot_in.alu_data = alu_data_mem;
        slot_in.dm_data  = dm_data_mem;
    end

    // One register per slot; slot 0 takes the MEM inputs, others take their predecessor.
    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        slot_t slot_d;
        if (k == 0) begin : g_head
            assign slot_d = slot_in;
        end else begin : g_body
            assign slot_d = slot_q[k-1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slot_q[k] <= '0;
            end else if (flush) begin
                slot_q[k] <= '0;
            end else if (!stall) begin
                slot_q[k] <= slot_d;
            end
        end
    end

    assign last = slot_q[STAGES-1];

    logic [XLEN-1:0] byte_w;
    logic [XLEN-1:0] half_w;
    logic [XLEN-1:0] load_val;
    logic            mis_raw;

    // Halfwords select on off[1] only, so a misaligned LH still returns a defined lane.
    assign byte_w = last.dm_data >> {last.off, 3'b000};
    assign half_w = last.dm_data >> {last.off[1], 4'b0000};

    always_comb begin
        load_val = last.dm_data;
        mis_raw  = 1'b0;
        case (last.funct3)
            3'b000: load_val = {{(XLEN-8){byte_w[7]}}, byte_w[7:0]};
            3'b100: load_val = {{(XLEN-8){1'b0}}, byte_w[7:0]};
            3'b001: begin
                load_val = {{(XLEN-16){half_w[15]}}, half_w[15:0]};
                mis_raw  = last.off[0];
            end
            3'b101: begin
                load_val = {{(XLEN-16){1'b0}}, half_w[15:0]};
                mis_raw  = last.off[0];
            end
            3'b010: mis_raw = (last.off != 2'b00);
            default: load_val = last.dm_data;
        endcase
    end

    assign valid_wb     = last.valid;
    assign rd_wb        = last.valid ? last.rd : '0;
    assign reg_write_wb = last.valid & last.im_to_rf & (last.rd != '0);
    assign wb_data      = !last.valid ? '0 : (last.load ? load_val : last.alu_data);
    assign misalign_wb  = last.valid & last.load & mis_raw;
    assign fwd_rs1      = reg_write_wb & (last.rd == rs1_ex);
    assign fwd_rs2      = reg_write_wb & (last.rd == rs2_ex);

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe: four instances (STAGES 1..4) share one stimulus
// stream; a queue-based reference model predicts every output each cycle.
module tb_mem_wb_pipe;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] wb;
        logic        mis;
        logic        f1;
        logic        f2;
    } out_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        im;
        logic        ld;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] dm;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        valid_mem = 1'b0;
    logic [4:0]  rd_mem = '0;
    logic        im_to_rf_mem = 1'b0;
    logic        load_mem = 1'b0;
    logic [2:0]  funct3_mem = '0;
    logic [31:0] alu_data_mem = '0;
    logic [31:0] dm_data_mem = '0;
    logic [4:0]  rs1_ex = '0;
    logic [4:0]  rs2_ex = '0;

    logic        v_o   [4];
    logic [4:0]  rd_o  [4];
    logic        rw_o  [4];
    logic [31:0] wb_o  [4];
    logic        mis_o [4];
    logic        f1_o  [4];
    logic        f2_o  [4];

    int checks = 0;
    int errors = 0;

    txn_t mq [4][$];
    out_t exp_q [4][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_wb_pipe #(.XLEN(32), .RA_W(5), .STAGES(g + 1)) u_dut (
            .clk(clk), .rst(rst), .stall(stall), .flush(flush),
            .valid_mem(valid_mem), .rd_mem(rd_mem), .im_to_rf_mem(im_to_rf_mem),
            .load_mem(load_mem), .funct3_mem(funct3_mem),
            .alu_data_mem(alu_data_mem), .dm_data_mem(dm_data_mem),
            .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
            .valid_wb(v_o[g]), .rd_wb(rd_o[g]), .reg_write_wb(rw_o[g]),
            .wb_data(wb_o[g]), .misalign_wb(mis_o[g]),
            .fwd_rs1(f1_o[g]), .fwd_rs2(f2_o[g])
        );
    end

    function automatic out_t observe(input int g);
        out_t o;
        o.valid = v_o[g];
        o.rd    = rd_o[g];
        o.rw    = rw_o[g];
        o.wb    = wb_o[g];
        o.mis   = mis_o[g];
        o.f1    = f1_o[g];
        o.f2    = f2_o[g];
        return o;
    endfunction

    // Reference: outputs derived directly from the write-back rules.
    function automatic out_t predict(input txn_t t, input logic [4:0] r1, input logic [4:0] r2);
        out_t o = '0;
        int unsigned off, b, h;
        if (!t.valid) return o;
        off     = int'(t.alu[1:0]);
        o.valid = 1'b1;
        o.rd    = t.rd;
        o.rw    = t.im && (t.rd != 0);
        o.wb    = t.alu;
        if (t.ld) begin
            b = (t.dm >> (8 * off)) & 32'hFF;
            h = (t.dm >> (16 * (off / 2))) & 32'hFFFF;
            case (t.f3)
                3'd0: o.wb = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
                3'd4: o.wb = b;
                3'd1: begin o.wb = (h >= 32768) ? (h | 32'hFFFF_0000) : h; o.mis = (off % 2) == 1; end
                3'd5: begin o.wb = h; o.mis = (off % 2) == 1; end
                3'd2: begin o.wb = t.dm; o.mis = off != 0; end
                default: o.wb = t.dm;
            endcase
        end
        o.f1 = o.rw && (t.rd == r1);
        o.f2 = o.rw && (t.rd == r2);
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int g = 0; g < 4; g++) begin
            mq[g].delete();
            for (int k = 0; k <= g; k++) mq[g].push_back('0);
        end
    endtask

    // Drive one cycle, advance the model at the edge, queue expectations.
    task automatic step(input logic v, input logic [4:0] rd, input logic im, input logic ld,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] dm,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic st, input logic fl);
        txn_t t;
        valid_mem = v; rd_mem = rd; im_to_rf_mem = im; load_mem = ld; funct3_mem = f3;
        alu_data_mem = alu; dm_data_mem = dm; rs1_ex = r1; rs2_ex = r2;
        stall = st; flush = fl;
        t = '{valid: v, rd: rd, im: im, ld: ld, f3: f3, alu: alu, dm: dm};
        @(posedge clk);
        for (int g = 0; g < 4; g++) begin
            if (fl) begin
                for (int k = 0; k <= g; k++) mq[g][k] = '0;
            end else if (!st) begin
                mq[g].push_front(t);
                void'(mq[g].pop_back());
            end
            exp_q[g].push_back(predict(mq[g][$], r1, r2));
        end
        @(negedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] alu);
        step(1'b1, rd, 1'b1, 1'b0, 3'd0, alu, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic load_op(input logic [2:0] f3, input logic [1:0] off);
        step(1'b1, 5'd3, 1'b1, 1'b1, f3, {30'h0000_0400, off}, 32'h80FF_7F01,
             5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (exp_q[g].size() > 0) begin
                out_t e, a;
                e = exp_q[g].pop_front();
                a = observe(g);
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL scoreboard_s%0d t=%0t: got v=%b rd=%0d rw=%b wb=%h mis=%b f1=%b f2=%b expected v=%b rd=%0d rw=%b wb=%h mis=%b f1=%b f2=%b",
                             g + 1, $time, a.valid, a.rd, a.rw, a.wb, a.mis, a.f1, a.f2,
                             e.valid, e.rd, e.rw, e.wb, e.mis, e.f1, e.f2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 4; g++) chk($sformatf("reset_state_s%0d", g + 1), 32'(observe(g)), 32'h0);
        rst = 1'b0;
        #1;

        // ALU write-back
        alu_op(5'd5, 32'h1234_5678);
        chk("alu_reg_write", 32'(rw_o[0]), 32'd1);
        chk("alu_rd", 32'(rd_o[0]), 32'd5);
        chk("alu_wb_data", wb_o[0], 32'h1234_5678);

        // Loads against dm=0x80FF_7F01
        load_op(3'd0, 2'd3); chk("lb_off3", wb_o[0], 32'hFFFF_FF80);
        load_op(3'd4, 2'd3); chk("lbu_off3", wb_o[0], 32'h0000_0080);
        load_op(3'd1, 2'd2); chk("lh_off2", wb_o[0], 32'hFFFF_80FF);
        load_op(3'd5, 2'd0); chk("lhu_off0", wb_o[0], 32'h0000_7F01);
        load_op(3'd2, 2'd0); chk("lw_off0", wb_o[0], 32'h80FF_7F01);
        chk("lw_off0_mis", 32'(mis_o[0]), 32'd0);
        load_op(3'd2, 2'd1); chk("lw_off1_mis", 32'(mis_o[0]), 32'd1);
        load_op(3'd1, 2'd1); chk("lh_off1_mis", 32'(mis_o[0]), 32'd1);

        // x0 suppression and forwarding
        step(1'b1, 5'd0, 1'b1, 1'b0, 3'd0, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("x0_reg_write", 32'(rw_o[0]), 32'd0);
        chk("x0_fwd_rs1", 32'(f1_o[0]), 32'd0);
        step(1'b1, 5'd7, 1'b1, 1'b0, 3'd0, 32'h77, 32'h0, 5'd7, 5'd8, 1'b0, 1'b0);
        chk("fwd_rs1_hit", 32'(f1_o[0]), 32'd1);
        chk("fwd_rs2_miss", 32'(f2_o[0]), 32'd0);

        // Stall/flush on the STAGES=3 instance
        repeat (4) idle();
        alu_op(5'd9, 32'h0000_A5A5);
        step(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0);
        chk("stall_hold_s1_wb", wb_o[0], 32'h0000_A5A5);
        step(1'b1, 5'd4, 1'b1, 1'b0, 3'd0, 32'h1111, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0);
        chk("stall_hold_s1_rd", 32'(rd_o[0]), 32'd9);
        idle();
        chk("s3_not_yet_valid", 32'(v_o[2]), 32'd0);
        idle();
        chk("s3_arrives_valid", 32'(v_o[2]), 32'd1);
        chk("s3_arrives_wb", wb_o[2], 32'h0000_A5A5);
        alu_op(5'd6, 32'h66);
        step(1'b1, 5'd6, 1'b1, 1'b0, 3'd0, 32'h66, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1);
        for (int g = 0; g < 4; g++) chk($sformatf("stall_flush_valid_s%0d", g + 1), 32'(v_o[g]), 32'd0);

        // Random stream
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(3) != 0), 5'($urandom_range(7)), 1'($urandom),
                 1'($urandom), 3'($urandom), $urandom, $urandom,
                 5'($urandom_range(7)), 5'($urandom_range(7)),
                 ($urandom_range(7) == 0), ($urandom_range(15) == 0));
        end

        // Asynchronous reset with slots full
        for (int i = 0; i < 4; i++) alu_op(5'(10 + i), 32'(32'h100 + i));
        chk("prefill_s4_valid", 32'(v_o[3]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) chk($sformatf("async_reset_s%0d", g + 1), 32'(observe(g)), 32'h0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        repeat (3) idle();
        for (int g = 0; g < 4; g++) chk($sformatf("post_reset_s%0d", g + 1), 32'(observe(g)), 32'h0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
